// File: rtl/sudoku_checker.sv
// rtl/sudoku_checker.sv - sequential validator for a solved 9x9 sudoku grid
// Latches candidate and puzzle on start, checks clues, then one unit per cycle.
module sudoku_checker (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [0:323] sudoku,
  input  logic [0:323] sudoku_given,
  output logic         busy,
  output logic         done,
  output logic         valid,
  output logic         fail_given,
  output logic [4:0]   fail_unit
);

  typedef enum logic [1:0] {IDLE, GIVEN, UNIT, DONE} state_t;

  localparam logic [4:0] UNIT_NONE = 5'd31;
  localparam logic [4:0] UNIT_LAST = 5'd26;

  state_t       state, state_nx;
  logic [0:323] grid, grid_nx;
  logic [0:323] givens, givens_nx;
  logic [4:0]   u, u_nx;
  logic [4:0]   fail_unit_nx;
  logic         done_nx, valid_nx, fail_given_nx;
  logic         given_bad;
  logic         unit_bad;

  // Units 0-8 are rows, 9-17 columns, 18-26 boxes; pos walks the unit row-major.
  function automatic logic [6:0] cell_index(input logic [4:0] unit, input logic [3:0] pos);
    logic [3:0] r, c, b;
    r = '0;
    c = '0;
    b = '0;
    if (unit < 5'd9) begin
      r = unit[3:0];
      c = pos;
    end else if (unit < 5'd18) begin
      r = pos;
      c = 4'(unit - 5'd9);
    end else begin
      b = 4'(unit - 5'd18);
      r = 4'(3 * (b / 3) + pos / 3);
      c = 4'(3 * (b % 3) + pos % 3);
    end
    return 7'(r * 9 + c);
  endfunction

  function automatic logic [3:0] cell_of(input logic [0:323] g, input logic [6:0] k);
    return g[4*k +: 4];
  endfunction

  always_comb begin
    given_bad = 1'b0;
    for (int k = 0; k < 81; k++) begin
      if (cell_of(givens, 7'(k)) != 4'd0 && cell_of(givens, 7'(k)) != cell_of(grid, 7'(k)))
        given_bad = 1'b1;
    end
  end

  // Out-of-range cells fail directly; otherwise a full one-hot OR proves a permutation.
  always_comb begin
    logic [8:0] mask;
    logic [3:0] v;
    logic       range_bad;
    mask      = '0;
    v         = '0;
    range_bad = 1'b0;
    for (int p = 0; p < 9; p++) begin
      v = cell_of(grid, cell_index(u, 4'(p)));
      if (v == 4'd0 || v > 4'd9)
        range_bad = 1'b1;
      else
        mask = mask | (9'd1 << (v - 4'd1));
    end
    unit_bad = range_bad || (mask != 9'h1FF);
  end

  assign busy = (state == GIVEN) || (state == UNIT);

  always_comb begin
    state_nx      = state;
    grid_nx       = grid;
    givens_nx     = givens;
    u_nx          = u;
    done_nx       = done;
    valid_nx      = valid;
    fail_given_nx = fail_given;
    fail_unit_nx  = fail_unit;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          grid_nx       = sudoku;
          givens_nx     = sudoku_given;
          u_nx          = '0;
          done_nx       = 1'b0;
          valid_nx      = 1'b0;
          fail_given_nx = 1'b0;
          fail_unit_nx  = UNIT_NONE;
          state_nx      = GIVEN;
        end
      end
      GIVEN: begin
        if (given_bad) begin
          fail_given_nx = 1'b1;
          valid_nx      = 1'b0;
          done_nx       = 1'b1;
          state_nx      = DONE;
        end else begin
          u_nx     = '0;
          state_nx = UNIT;
        end
      end
      UNIT: begin
        if (unit_bad) begin
          fail_unit_nx = u;
          valid_nx     = 1'b0;
          done_nx      = 1'b1;
          state_nx     = DONE;
        end else if (u == UNIT_LAST) begin
          valid_nx = 1'b1;
          done_nx  = 1'b1;
          state_nx = DONE;
        end else begin
          u_nx = u + 5'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grid       <= '0;
      givens     <= '0;
      u          <= '0;
      done       <= 1'b0;
      valid      <= 1'b0;
      fail_given <= 1'b0;
      fail_unit  <= UNIT_NONE;
    end else begin
      state      <= state_nx;
      grid       <= grid_nx;
      givens     <= givens_nx;
      u          <= u_nx;
      done       <= done_nx;
      valid      <= valid_nx;
      fail_given <= fail_given_nx;
      fail_unit  <= fail_unit_nx;
    end
  end

endmodule

// File: tb/tb_sudoku_checker.sv
// tb/tb_sudoku_checker.sv - directed self-checking bench for sudoku_checker
// Linear directed steps; expected values are hand-derived from the grid contents.
module tb_sudoku_checker;

  logic         clk;
  logic         rst;
  logic         start;
  logic [0:323] sudoku;
  logic [0:323] sudoku_given;
  logic         busy, done, valid, fail_given;
  logic [4:0]   fail_unit;

  int total = 0;
  int bad   = 0;
  int n;
  logic busy_ok;
  logic hold_ok;

  logic [0:323] good_grid;
  logic [0:323] swap_grid;
  logic [0:323] zero_grid;
  logic [0:323] given9;

  sudoku_checker dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sudoku       (sudoku),
    .sudoku_given (sudoku_given),
    .busy         (busy),
    .done         (done),
    .valid        (valid),
    .fail_given   (fail_given),
    .fail_unit    (fail_unit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive start across one edge (E0); returns 1 ns after that edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done, starting from edge count n0; bounded at 60.
  task automatic wait_done(input int n0, output int cnt, output logic bsy);
    cnt = n0;
    bsy = 1'b1;
    while (!done && cnt < 60) begin
      if (!busy) bsy = 1'b0;
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  initial begin
    good_grid = 324'h123456789456789123789123456234567891567891234891234567345678912678912345912345678;
    swap_grid = 324'h213456789456789123789123456234567891567891234891234567345678912678912345912345678;
    zero_grid = good_grid;
    zero_grid[160 +: 4] = 4'h0;
    given9 = '0;
    given9[0 +: 4] = 4'h9;

    rst = 1'b0;
    start = 1'b0;
    sudoku = good_grid;
    sudoku_given = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_fail_given", 32'(fail_given), 0);
    chk("reset_fail_unit", 32'(fail_unit), 31);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Valid grid: 28 cycles busy, then pass
    pulse_start();
    chk("valid_busy_e0", 32'(busy), 1);
    chk("valid_fail_unit_busy", 32'(fail_unit), 31);
    wait_done(0, n, busy_ok);
    chk("valid_latency", 32'(n), 28);
    chk("valid_busy_held", 32'(busy_ok), 1);
    chk("valid_busy_after", 32'(busy), 0);
    chk("valid_valid", 32'(valid), 1);
    chk("valid_fail_given", 32'(fail_given), 0);
    chk("valid_fail_unit", 32'(fail_unit), 31);

    // Swapped cells 0/1: column 0 repeats a 2
    sudoku = swap_grid;
    pulse_start();
    chk("swap_done_cleared", 32'(done), 0);
    wait_done(0, n, busy_ok);
    chk("swap_latency", 32'(n), 11);
    chk("swap_valid", 32'(valid), 0);
    chk("swap_fail_unit", 32'(fail_unit), 9);
    chk("swap_fail_given", 32'(fail_given), 0);

    // Given clue 9 at cell 0 contradicts candidate 1
    sudoku = good_grid;
    sudoku_given = given9;
    pulse_start();
    wait_done(0, n, busy_ok);
    chk("given_latency", 32'(n), 1);
    chk("given_fail_given", 32'(fail_given), 1);
    chk("given_fail_unit", 32'(fail_unit), 31);
    chk("given_valid", 32'(valid), 0);

    // Cell 40 zero: row 4 fails first
    sudoku = zero_grid;
    sudoku_given = '0;
    pulse_start();
    chk("zero_fail_given_cleared", 32'(fail_given), 0);
    wait_done(0, n, busy_ok);
    chk("zero_latency", 32'(n), 6);
    chk("zero_fail_unit", 32'(fail_unit), 4);
    chk("zero_valid", 32'(valid), 0);

    // Reset mid-check
    sudoku = good_grid;
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_fail_unit", 32'(fail_unit), 31);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    wait_done(0, n, busy_ok);
    chk("midrst_latency", 32'(n), 28);
    chk("midrst_valid_after", 32'(valid), 1);

    // Start while busy is ignored; input change has no effect
    sudoku = good_grid;
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    sudoku = swap_grid;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(6, n, busy_ok);
    chk("ignore_latency", 32'(n), 28);
    chk("ignore_valid", 32'(valid), 1);
    chk("ignore_fail_unit", 32'(fail_unit), 31);
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!done || !valid || busy) hold_ok = 1'b0;
    end
    chk("done_hold_20", 32'(hold_ok), 1);
    pulse_start();
    chk("restart_done_low", 32'(done), 0);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_valid_cleared", 32'(valid), 0);
    wait_done(0, n, busy_ok);
    chk("restart_latency", 32'(n), 11);
    chk("restart_fail_unit", 32'(fail_unit), 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
